// File: rtl/router_pkg.sv
// Shared constants and header helpers for the router datapath register stage
// and its check accumulator.
package router_pkg;

  localparam int unsigned CHK_XOR   = 0;
  localparam int unsigned CHK_SUM   = 1;
  localparam int unsigned HDR_MAX_W = 64;

  function automatic int unsigned len_w(input int unsigned data_w, input int unsigned addr_w);
    return data_w - addr_w;
  endfunction

  // Header fields travel at the widest supported width; callers narrow the result.
  function automatic logic [HDR_MAX_W-1:0] hdr_len(input logic [HDR_MAX_W-1:0] hdr,
                                                   input int unsigned addr_w);
    return hdr >> addr_w;
  endfunction

  function automatic logic [HDR_MAX_W-1:0] hdr_addr(input logic [HDR_MAX_W-1:0] hdr,
                                                    input int unsigned addr_w);
    return hdr & ((HDR_MAX_W'(1) << addr_w) - HDR_MAX_W'(1));
  endfunction

endpackage

// File: rtl/router_chk_acc.sv
// Clear/fold check accumulator: XOR parity or modular additive checksum.
module router_chk_acc
  import router_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHK_MODE = CHK_XOR
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clr,
  input  logic              fold,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] folded_c;

  always_comb begin
    folded_c = acc ^ data;
    if (CHK_MODE == CHK_SUM) folded_c = acc + data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)   acc <= '0;
    else if (clr)  acc <= '0;
    else if (fold) acc <= folded_c;
  end

endmodule

// File: rtl/router_reg_gen.sv
// Router datapath register stage: header latch, FIFO write mux with full replay,
// end-of-packet check/length verification and saturating statistics.
module router_reg_gen
  import router_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned CHK_MODE = CHK_XOR,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  input  logic              clr_stats,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] dout,
  output logic              low_pkt_valid,
  output logic              parity_done,
  output logic              chk_err,
  output logic              len_err,
  output logic              err,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned LEN_W  = len_w(DATA_W, ADDR_W);
  localparam int unsigned BCNT_W = LEN_W + 1;

  logic [DATA_W-1:0] header, hold, chk_byte, acc, fold_data;
  logic [LEN_W-1:0]  len;
  logic [BCNT_W-1:0] byte_cnt;
  logic fold_pay, fold, ld_capture, laf_capture;
  logic parity_done_q, err_q, pd_rise, err_rise, chk_mis, len_mis;

  assign fold_pay    = ld_state & pkt_valid & ~full_state;
  assign fold        = lfd_state | fold_pay;
  assign fold_data   = lfd_state ? header : data_in;
  assign ld_capture  = ld_state & ~pkt_valid & ~fifo_full;
  assign laf_capture = laf_state & low_pkt_valid & ~parity_done;
  assign pd_rise     = parity_done & ~parity_done_q;
  assign err_rise    = err & ~err_q;
  assign len         = LEN_W'(hdr_len(HDR_MAX_W'(header), ADDR_W));
  assign chk_mis     = acc != chk_byte;
  assign len_mis     = byte_cnt != {1'b0, len};

  router_chk_acc #(
    .DATA_W  (DATA_W),
    .CHK_MODE(CHK_MODE)
  ) u_chk_acc (
    .clock (clock),
    .resetn(resetn),
    .clr   (detect_add),
    .fold  (fold),
    .data  (fold_data),
    .acc   (acc)
  );

  // Header, FIFO write data, replay byte and check byte; a check byte that hit a
  // full FIFO sits in the replay byte and is taken from there in laf_state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header   <= '0;
      hold     <= '0;
      chk_byte <= '0;
      dout     <= '0;
    end else begin
      if (detect_add && pkt_valid) header <= data_in;
      if (ld_state && fifo_full)   hold   <= data_in;
      if (lfd_state)                   dout <= header;
      else if (ld_state && !fifo_full) dout <= data_in;
      else if (laf_state)              dout <= hold;
      if (ld_capture)       chk_byte <= data_in;
      else if (laf_capture) chk_byte <= hold;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                           byte_cnt <= '0;
    else if (detect_add)                   byte_cnt <= '0;
    else if (fold_pay && byte_cnt != '1)   byte_cnt <= byte_cnt + BCNT_W'(1);
  end

  // Packet-end status and error flags; detect_add clears win over a pending set.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      low_pkt_valid <= 1'b0;
      parity_done   <= 1'b0;
      parity_done_q <= 1'b0;
      err_q         <= 1'b0;
      chk_err       <= 1'b0;
      len_err       <= 1'b0;
      err           <= 1'b0;
    end else begin
      parity_done_q <= parity_done;
      err_q         <= err;
      if (ld_state && !pkt_valid) low_pkt_valid <= 1'b1;
      else if (rst_int_reg)       low_pkt_valid <= 1'b0;
      if (detect_add)                       parity_done <= 1'b0;
      else if (ld_capture || laf_capture)   parity_done <= 1'b1;
      if (detect_add) begin
        chk_err <= 1'b0;
        len_err <= 1'b0;
        err     <= 1'b0;
      end else if (pd_rise) begin
        chk_err <= chk_mis;
        len_err <= len_mis;
        err     <= chk_mis | len_mis;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else if (clr_stats) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (pd_rise && pkt_cnt != '1)  pkt_cnt <= pkt_cnt + CNT_W'(1);
      if (err_rise && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_router_reg_gen.sv
// Bench for router_reg_gen: an XOR/16-bit-counter instance and a checksum/2-bit-counter
// instance driven in parallel, with a dout scoreboard and a small packet model.
module tb_router_reg_gen;

  logic       clock, resetn, pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg, clr_stats;
  logic [7:0] data_in, dout_x, dout_s;
  logic       lpv_x, pd_x, ce_x, le_x, er_x, lpv_s, pd_s, ce_s, le_s, er_s;
  logic [15:0] pkt_x, errc_x;
  logic [1:0]  pkt_s, errc_s;

  router_reg_gen #(.DATA_W(8), .ADDR_W(2), .CHK_MODE(0), .CNT_W(16)) dut_x (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .clr_stats(clr_stats), .data_in(data_in), .dout(dout_x), .low_pkt_valid(lpv_x),
    .parity_done(pd_x), .chk_err(ce_x), .len_err(le_x), .err(er_x),
    .pkt_cnt(pkt_x), .err_cnt(errc_x));

  router_reg_gen #(.DATA_W(8), .ADDR_W(2), .CHK_MODE(1), .CNT_W(2)) dut_s (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .clr_stats(clr_stats), .data_in(data_in), .dout(dout_s), .low_pkt_valid(lpv_s),
    .parity_done(pd_s), .chk_err(ce_s), .len_err(le_s), .err(er_s),
    .pkt_cnt(pkt_s), .err_cnt(errc_s));

  logic [2:0]  flg [2];
  logic [15:0] pcnt [2];
  logic [15:0] ecnt [2];
  logic        pdo [2];
  logic        lpvo [2];
  assign flg[0]  = {ce_x, le_x, er_x};
  assign flg[1]  = {ce_s, le_s, er_s};
  assign pcnt[0] = pkt_x;
  assign pcnt[1] = {14'd0, pkt_s};
  assign ecnt[0] = errc_x;
  assign ecnt[1] = {14'd0, errc_s};
  assign pdo[0]  = pd_x;
  assign pdo[1]  = pd_s;
  assign lpvo[0] = lpv_x;
  assign lpvo[1] = lpv_s;

  int checks = 0;
  int failures = 0;
  logic [7:0] pay [$];
  logic [7:0] exp_q [$];
  logic [7:0] obs_x [$];
  logic [7:0] obs_s [$];

  logic        pd_n [2], lpv_n [2], lpv_n1 [2];
  logic [2:0]  flg_n [2], flg_n1 [2], flg_da [2], ef [2];
  logic [15:0] pkt_n1 [2], pkt_da [2], ecnt_n2 [2];
  int ep [2] = '{0, 0};
  int ee [2] = '{0, 0};
  int cmax [2] = '{65535, 3};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: fold header and payload, compare with the check byte and header length.
  function automatic logic [2:0] model_flags(input int mode, input logic [7:0] hdr,
                                             input logic [7:0] chk);
    logic [7:0] a;
    int n;
    logic ce, le;
    a = hdr;
    foreach (pay[i]) a = (mode == 1) ? 8'(a + pay[i]) : (a ^ pay[i]);
    n  = (pay.size() > 127) ? 127 : pay.size();
    ce = (a != chk);
    le = (n != int'(hdr >> 2));
    return {ce, le, ce | le};
  endfunction

  task automatic model_pkt(input logic [7:0] hdr, input logic [7:0] chk);
    for (int d = 0; d < 2; d++) begin
      ef[d] = model_flags(d, hdr, chk);
      if (ep[d] < cmax[d]) ep[d]++;
      if (ef[d][0] && ee[d] < cmax[d]) ee[d]++;
    end
  endtask

  task automatic cyc(input logic da, lfd, ld, laf, fs, ff, pv, input logic [7:0] d,
                     input logic wr, input logic [7:0] e);
    detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
    full_state = fs; fifo_full = ff; pkt_valid = pv; data_in = d;
    @(posedge clock); #1;
    if (wr) begin
      exp_q.push_back(e);
      obs_x.push_back(dout_x);
      obs_s.push_back(dout_s);
    end
  endtask

  // FSM-like packet sequence; stops right after the check-byte edge.
  task automatic drive_pkt(input logic [7:0] hdr, input logic [7:0] chk, input int full_idx);
    cyc(1, 0, 0, 0, 0, 0, 1, hdr, 0, 8'h00);
    for (int d = 0; d < 2; d++) begin flg_da[d] = flg[d]; pkt_da[d] = pcnt[d]; end
    cyc(0, 1, 0, 0, 0, 0, 1, 8'hA5, 1, hdr);
    for (int i = 0; i < pay.size(); i++) begin
      if (i == full_idx) begin
        cyc(0, 0, 1, 0, 0, 1, 1, pay[i], 0, 8'h00);
        cyc(0, 0, 0, 0, 1, 1, 1, 8'h5A, 0, 8'h00);
        cyc(0, 0, 0, 1, 0, 0, 1, 8'h5A, 1, pay[i]);
      end else begin
        cyc(0, 0, 1, 0, 0, 0, 1, pay[i], 1, pay[i]);
      end
    end
    cyc(0, 0, 1, 0, 0, 0, 0, chk, 1, chk);
    for (int d = 0; d < 2; d++) begin pd_n[d] = pdo[d]; lpv_n[d] = lpvo[d]; flg_n[d] = flg[d]; end
  endtask

  task automatic finish_pkt();
    rst_int_reg = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    rst_int_reg = 1'b0;
    for (int d = 0; d < 2; d++) begin flg_n1[d] = flg[d]; pkt_n1[d] = pcnt[d]; lpv_n1[d] = lpvo[d]; end
    cyc(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    for (int d = 0; d < 2; d++) ecnt_n2[d] = ecnt[d];
  endtask

  task automatic test_reset();
    resetn = 1'b0; rst_int_reg = 1'b0; clr_stats = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    checks++;
    if ({dout_x, lpv_x, pd_x, ce_x, le_x, er_x, pkt_x, errc_x} !== 45'd0) begin
      failures++; $display("FAIL reset_x: outputs %h expected 0", {dout_x, lpv_x, pd_x, ce_x, le_x, er_x, pkt_x, errc_x});
    end
    checks++;
    if ({dout_s, lpv_s, pd_s, ce_s, le_s, er_s, pkt_s, errc_s} !== 17'd0) begin
      failures++; $display("FAIL reset_s: outputs %h expected 0", {dout_s, lpv_s, pd_s, ce_s, le_s, er_s, pkt_s, errc_s});
    end
    resetn = 1'b1;
  endtask

  task automatic test_good_xor();
    logic [7:0] e, ox, os;
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drive_pkt(8'h16, 8'h07, -1); finish_pkt(); model_pkt(8'h16, 8'h07);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ox = obs_x.pop_front(); os = obs_s.pop_front();
      checks++;
      if (ox !== e || os !== e) begin failures++; $display("FAIL good_xor dout: got %h/%h expected %h", ox, os, e); end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pd_n[d] !== 1'b1 || flg_n[d] !== 3'b000) begin
        failures++; $display("FAIL good_xor latency dut%0d: parity_done=%b flags=%b expected 1/000", d, pd_n[d], flg_n[d]);
      end
      checks++;
      if (lpv_n[d] !== 1'b1 || lpv_n1[d] !== 1'b0) begin
        failures++; $display("FAIL good_xor low_pkt_valid dut%0d: got %b,%b expected 1,0", d, lpv_n[d], lpv_n1[d]);
      end
      checks++;
      if (flg_n1[d] !== ef[d] || pkt_n1[d] !== 16'(ep[d]) || ecnt_n2[d] !== 16'(ee[d])) begin
        failures++; $display("FAIL good_xor status dut%0d: flags=%b pkt=%0d err=%0d expected %b %0d %0d",
                             d, flg_n1[d], pkt_n1[d], ecnt_n2[d], ef[d], ep[d], ee[d]);
      end
    end
  endtask

  // Used for bad check byte, checksum mode, short packet and fifo-full replay.
  task automatic test_packet(input string name, input logic [7:0] chk, input int n_pay, input int full_idx);
    logic [7:0] e, ox, os;
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    while (pay.size() > n_pay) void'(pay.pop_back());
    drive_pkt(8'h16, chk, full_idx); finish_pkt(); model_pkt(8'h16, chk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ox = obs_x.pop_front(); os = obs_s.pop_front();
      checks++;
      if (ox !== e || os !== e) begin failures++; $display("FAIL %s dout: got %h/%h expected %h", name, ox, os, e); end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (flg_n[d] !== 3'b000 || flg_n1[d] !== ef[d]) begin
        failures++; $display("FAIL %s flags dut%0d: got %b then %b expected 000 then %b", name, d, flg_n[d], flg_n1[d], ef[d]);
      end
      checks++;
      if (pkt_n1[d] !== 16'(ep[d]) || ecnt_n2[d] !== 16'(ee[d])) begin
        failures++; $display("FAIL %s counters dut%0d: pkt=%0d err=%0d expected %0d %0d", name, d, pkt_n1[d], ecnt_n2[d], ep[d], ee[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drive_pkt(8'h16, 8'h2E, -1);
    for (int d = 0; d < 2; d++) if (ep[d] < cmax[d]) ep[d]++;
    drive_pkt(8'h16, 8'h07, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (flg_da[d] !== 3'b000 || pkt_da[d] !== 16'(ep[d])) begin
        failures++; $display("FAIL b2b clear_wins dut%0d: flags=%b pkt=%0d expected 000 %0d", d, flg_da[d], pkt_da[d], ep[d]);
      end
    end
    finish_pkt(); model_pkt(8'h16, 8'h07);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (flg_n1[d] !== ef[d] || ecnt_n2[d] !== 16'(ee[d])) begin
        failures++; $display("FAIL b2b second dut%0d: flags=%b err=%0d expected %b %0d", d, flg_n1[d], ecnt_n2[d], ef[d], ee[d]);
      end
    end
    exp_q.delete(); obs_x.delete(); obs_s.delete();
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, 0, 0, 0, 0, 1, 8'h16, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 0, 1, 8'hA5, 1, 8'h16);
    cyc(0, 0, 1, 0, 0, 0, 1, 8'h11, 1, 8'h11);
    cyc(0, 0, 1, 0, 0, 0, 1, 8'h22, 1, 8'h22);
    cyc(0, 0, 1, 0, 0, 0, 1, 8'h33, 1, 8'h33);
    resetn = 1'b0;
    #2;
    checks++;
    if ({dout_x, lpv_x, pd_x, ce_x, le_x, er_x, pkt_x, errc_x, dout_s, lpv_s, pd_s, ce_s, le_s, er_s, pkt_s, errc_s} !== 62'd0) begin
      failures++; $display("FAIL reset_mid outputs: x=%h s=%h expected 0",
                           {dout_x, lpv_x, pd_x, ce_x, le_x, er_x, pkt_x, errc_x}, {dout_s, lpv_s, pd_s, ce_s, le_s, er_s, pkt_s, errc_s});
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    resetn = 1'b1;
    exp_q.delete(); obs_x.delete(); obs_s.delete();
    ep = '{0, 0}; ee = '{0, 0};
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drive_pkt(8'h16, 8'h07, -1); finish_pkt(); model_pkt(8'h16, 8'h07);
    checks++;
    if (flg_n1[0] !== 3'b000 || pkt_n1[0] !== 16'd1 || ecnt_n2[0] !== 16'd0) begin
      failures++; $display("FAIL reset_mid next_pkt: flags=%b pkt=%0d err=%0d expected 000 1 0", flg_n1[0], pkt_n1[0], ecnt_n2[0]);
    end
    checks++;
    if (flg_n1[1] !== ef[1] || pkt_n1[1] !== 16'(ep[1]) || ecnt_n2[1] !== 16'(ee[1])) begin
      failures++; $display("FAIL reset_mid next_pkt_s: flags=%b pkt=%0d err=%0d expected %b %0d %0d", flg_n1[1], pkt_n1[1], ecnt_n2[1], ef[1], ep[1], ee[1]);
    end
    exp_q.delete(); obs_x.delete(); obs_s.delete();
  endtask

  task automatic test_err_sat();
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int k = 0; k < 3; k++) begin
      drive_pkt(8'h16, 8'h2E, -1); finish_pkt(); model_pkt(8'h16, 8'h2E);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ecnt_n2[d] !== 16'(ee[d]) || pkt_n1[d] !== 16'(ep[d])) begin
          failures++; $display("FAIL err_sat dut%0d pkt%0d: err=%0d pkt=%0d expected %0d %0d", d, k, ecnt_n2[d], pkt_n1[d], ee[d], ep[d]);
        end
      end
    end
    checks++;
    if (errc_s !== 2'b11) begin failures++; $display("FAIL err_sat held: err_cnt=%b expected 11", errc_s); end
    exp_q.delete(); obs_x.delete(); obs_s.delete();
  endtask

  task automatic test_clr_stats();
    clr_stats = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    clr_stats = 1'b0;
    ep = '{0, 0}; ee = '{0, 0};
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pcnt[d] !== 16'd0 || ecnt[d] !== 16'd0) begin
        failures++; $display("FAIL clr_stats dut%0d: pkt=%0d err=%0d expected 0 0", d, pcnt[d], ecnt[d]);
      end
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] e, ox, os;
    pay.delete();
    drive_pkt(8'h01, 8'h01, -1); finish_pkt(); model_pkt(8'h01, 8'h01);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ox = obs_x.pop_front(); os = obs_s.pop_front();
      checks++;
      if (ox !== e || os !== e) begin failures++; $display("FAIL zero_len dout: got %h/%h expected %h", ox, os, e); end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (flg_n1[d] !== 3'b000 || pkt_n1[d] !== 16'(ep[d]) || ecnt_n2[d] !== 16'd0) begin
        failures++; $display("FAIL zero_len dut%0d: flags=%b pkt=%0d err=%0d expected 000 %0d 0", d, flg_n1[d], pkt_n1[d], ecnt_n2[d], ep[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_xor();
    test_packet("bad_chk", 8'h2E, 5, -1);
    test_packet("chk_sum", 8'h15, 5, -1);
    test_packet("short", 8'h52, 4, -1);
    test_packet("fifo_full", 8'h07, 5, 2);
    test_back_to_back();
    test_reset_mid();
    test_err_sat();
    test_clr_stats();
    test_zero_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_reg_gen.md
# router_reg_gen

Parametrised successor to the router datapath register stage, sitting between the router FSM and the three output FIFOs. It latches the header and forwards the header/payload/parity bytes to the FIFO write bus. While the FIFO is full, it holds one byte and replays it in the load-after-full state. At the end of every packet it checks a configurable check byte and verifies the payload length against the header length field. It also keeps saturating packet and error statistics.

## Interface
- DATA_W, 8, byte width of the data bus (≥4)
- ADDR_W, 2, header address field width; LEN_W = DATA_W-ADDR_W
- CHK_MODE, 0, 0 = XOR parity, 1 = additive checksum mod 2^DATA_W
- CNT_W, 16, statistics counter width
- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- pkt_valid  in  1  source packet valid; falling edge marks the check byte
- fifo_full  in  1  selected FIFO full
- detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  FSM state decodes (one-hot)
- rst_int_reg  in  1  clears low_pkt_valid
- clr_stats  in  1  synchronous clear of pkt_cnt/err_cnt
- data_in  in  DATA_W  source byte
- dout  out  DATA_W  FIFO write data
- low_pkt_valid  out  1  check byte received
- parity_done  out  1  check byte captured
- chk_err, len_err, err  out  1 each  check mismatch, length mismatch, OR of both
- pkt_cnt, err_cnt  out  CNT_W  completed packets, errored packets

## Operation
- Header: the header register loads data_in when detect_add&pkt_valid. len = header[DATA_W-1:ADDR_W].
- dout:
  - lfd_state → header.
  - ld_state&!fifo_full → data_in.
  - laf_state → hold byte.
  - Otherwise dout holds its value.
- Hold byte: loads data_in when ld_state&fifo_full.
- Accumulator:
  - Clears on detect_add.
  - Folds in the header during lfd_state.
  - Folds in data_in when ld_state&pkt_valid&!full_state.
  - Fold is XOR (CHK_MODE=0) or modular add (CHK_MODE=1).
- Byte counter (LEN_W+1 bits):
  - Clears on detect_add.
  - Increments on the same condition as the accumulator, excluding lfd_state.
  - Saturates at all-ones.
- Packet check byte: captured when ld_state&!pkt_valid&!fifo_full, or when laf_state&low_pkt_valid&!parity_done.
- low_pkt_valid:
  - Set when ld_state&!pkt_valid.
  - Cleared by rst_int_reg; set wins if both occur together.
- parity_done:
  - Set on the check-byte capture cycle.
  - Cleared by detect_add.
- Error flags:
  - One cycle after parity_done rises: chk_err = (acc != check byte); len_err = (count != len).
  - err = chk_err|len_err.
  - All three flags clear on detect_add.
- Statistics:
  - pkt_cnt increments once per parity_done rise.
  - err_cnt increments once per err rise.
  - Both saturate at 2^CNT_W-1.
  - clr_stats has priority over increment.

## Timing
- Every output is 0 while resetn is low. Reset mid-packet discards the header, accumulator, counter and hold byte.
- dout is registered: data_in appears on dout one clock after it is sampled.
- Error-flag latency: parity_done rises at edge N; chk_err/len_err/err at edge N+1; err_cnt at edge N+2.
- pkt_cnt updates at edge N+1.
- A zero-length header is legal. A check byte immediately after the header compares acc=header, count=0.
- A length overflow (count saturated) always flags len_err when len < 2^LEN_W-1.
- detect_add in the same cycle as the error-flag set: the clear wins.

## Structure
- Shared package router_pkg holds:
  - CHK_XOR/CHK_SUM localparams.
  - A LEN_W derivation function.
  - Header field-extraction functions (len/addr).
- Sub-module router_chk_acc (DATA_W, CHK_MODE) implements the clear/fold accumulator and is reused by the future CRC mode.
- The top level holds the header, hold byte, counters and flag registers.

## Test plan
All scenarios use DATA_W=8 and ADDR_W=2.
- Good XOR packet: header 0x16, payload 0x11,0x22,0x33,0x44,0x55, check byte 0x07 → dout sequence 16,11,22,33,44,55,07; parity_done=1; err=0; pkt_cnt=1.
- Bad check byte: same packet with check byte 0x2E → chk_err=1, len_err=0, err=1 at parity_done+1; err_cnt=1.
- CHK_MODE=1: same payload, check byte 0x15 → err=0. Check byte 0x07 → chk_err=1.
- Short packet: header 0x16, payload 0x11,0x22,0x33,0x44, check byte 0x52 → chk_err=0, len_err=1.
- FIFO full: fifo_full=1 while ld_state and data_in=0x33, then full_state, then laf_state → dout=0x33 during laf. Check byte still 0x07 → err=0.
- Reset/clear:
  - resetn low after the third payload byte → all outputs 0. The next good packet completes with err=0.
  - Force err_cnt to all-ones, then send an errored packet → err_cnt stays all-ones.
  - clr_stats → both counters 0 next cycle.
